// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: data-bus controller between the core's data port and
// NUM_SLV memory-mapped slaves. Slave i owns addresses with addr[31:28]==i.
// One transaction is in flight at a time, and the core is stalled until the
// selected slave acknowledges it. Unmapped accesses complete with ERR_DATA
// and set the sticky bus_err flag.
// Optional feature: define MMIO_TIMEOUT_EN to abort accesses that receive no
// ack within TIMEOUT_CYC cycles.
module mmio_bus_ctrl #(
    parameter int          NUM_SLV     = 4,
    parameter int          TIMEOUT_CYC = 16,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_en,
    input  logic                   cpu_we,
    input  logic [31:0]            cpu_addr,
    input  logic [3:0]             cpu_sel,
    input  logic [31:0]            cpu_wdata,
    output logic [31:0]            cpu_rdata,
    output logic                   cpu_stall,
    output logic [NUM_SLV-1:0]     slv_en,
    output logic                   slv_we,
    output logic [31:0]            slv_addr,
    output logic [3:0]             slv_sel,
    output logic [31:0]            slv_wdata,
    input  logic [32*NUM_SLV-1:0]  slv_rdata,
    input  logic [NUM_SLV-1:0]     slv_ack,
    output logic                   bus_err,
    output logic [31:0]            err_addr
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [3:0]           region;
    logic [NUM_SLV-1:0]   region_hot;
    logic                 mapped;
    logic                 ack_hit;
    logic [31:0]          ack_rdata;
    logic                 timeout_hit;
    logic                 stall_c;
    logic [31:0]          rdata_q;

    assign region    = cpu_addr[31:28];
    assign cpu_rdata = rdata_q;
    // Reset forces the stall low even though IDLE normally mirrors cpu_en.
    assign cpu_stall = rst & stall_c;

    // Region decode and read-data selection from the enabled channel only.
    always_comb begin
        region_hot = '0;
        ack_rdata  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            region_hot[i] = (region == 4'(i));
            if (slv_en[i]) begin
                ack_rdata = slv_rdata[32*i +: 32];
            end
        end
        mapped  = |region_hot;
        ack_hit = |(slv_ack & slv_en);
    end

`ifdef MMIO_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;

    // Wait counter: zero outside ACCESS, counts ACCESS cycles without an ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state != ACCESS) begin
            wait_cnt <= '0;
        end else if (!ack_hit) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // An ack in the final cycle takes priority over the abort.
    assign timeout_hit = (state == ACCESS) && !ack_hit &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and stall decode.
    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        case (state)
            IDLE: begin
                stall_c = cpu_en;
                if (cpu_en) begin
                    state_nxt = mapped ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                stall_c = 1'b1;
                if (ack_hit || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, slave enable, read-data and error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slv_en    <= '0;
            slv_we    <= 1'b0;
            slv_addr  <= '0;
            slv_sel   <= '0;
            slv_wdata <= '0;
            rdata_q   <= '0;
            bus_err   <= 1'b0;
            err_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_en) begin
                        if (mapped) begin
                            slv_en    <= region_hot;
                            slv_we    <= cpu_we;
                            slv_addr  <= cpu_addr;
                            slv_sel   <= cpu_sel;
                            slv_wdata <= cpu_wdata;
                        end else begin
                            rdata_q  <= ERR_DATA;
                            bus_err  <= 1'b1;
                            err_addr <= cpu_addr;
                        end
                    end
                end
                ACCESS: begin
                    if (ack_hit) begin
                        slv_en  <= '0;
                        rdata_q <= ack_rdata;
                    end else if (timeout_hit) begin
                        slv_en   <= '0;
                        rdata_q  <= ERR_DATA;
                        bus_err  <= 1'b1;
                        err_addr <= slv_addr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Testbench for mmio_bus_ctrl: directed transactions with a scoreboard.
// The driver pushes expected completions and expected slave-enable pulses
// into queues; independent monitors pop and compare as the DUT produces them.
module tb_mmio_bus_ctrl;

    localparam int NUM_SLV = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  cpu_en = 1'b0;
    logic                  cpu_we = 1'b0;
    logic [31:0]           cpu_addr = '0;
    logic [3:0]            cpu_sel = '0;
    logic [31:0]           cpu_wdata = '0;
    logic [31:0]           cpu_rdata;
    logic                  cpu_stall;
    logic [NUM_SLV-1:0]    slv_en;
    logic                  slv_we;
    logic [31:0]           slv_addr;
    logic [3:0]            slv_sel;
    logic [31:0]           slv_wdata;
    logic [32*NUM_SLV-1:0] slv_rdata;
    logic [NUM_SLV-1:0]    slv_ack;
    logic [NUM_SLV-1:0]    resp_ack = '0;
    logic [NUM_SLV-1:0]    force_ack = '0;
    logic                  bus_err;
    logic [31:0]           err_addr;

    int n_tests = 0;
    int n_fail  = 0;

    // slave responder configuration
    int   ack_wait = 0;
    logic stray_en = 1'b0;
    int   stray_ch = 2;
    int   en_cyc   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        chk_rdata;
        logic        err;
        logic [31:0] eaddr;
        int          stall;
    } resp_t;

    typedef struct {
        logic [3:0]  en;
        int          cycles;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } en_t;

    resp_t exp_q[$];
    en_t   en_q[$];

    assign slv_rdata = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h1234_5678};
    assign slv_ack   = resp_ack | force_ack;

    mmio_bus_ctrl #(
        .NUM_SLV     (NUM_SLV),
        .TIMEOUT_CYC (16),
        .ERR_DATA    (32'hDEADBEEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_en    (cpu_en),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_sel   (cpu_sel),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .slv_en    (slv_en),
        .slv_we    (slv_we),
        .slv_addr  (slv_addr),
        .slv_sel   (slv_sel),
        .slv_wdata (slv_wdata),
        .slv_rdata (slv_rdata),
        .slv_ack   (slv_ack),
        .bus_err   (bus_err),
        .err_addr  (err_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave model: acks the enabled channel after ack_wait wait cycles,
    // optionally pulsing a non-selected channel's ack while waiting.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (slv_en != '0) begin
                if (en_cyc == ack_wait) resp_ack = slv_en;
                else if (stray_en)      resp_ack = 4'b0001 << stray_ch;
                else                    resp_ack = '0;
                en_cyc++;
            end else begin
                resp_ack = '0;
                en_cyc   = 0;
            end
        end
    end

    // Completion monitor: a stall falling edge marks DONE.
    initial begin
        logic  prev_stall;
        int    stall_cnt;
        resp_t r;
        prev_stall = 1'b0;
        stall_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
                stall_cnt  = 0;
            end else begin
                if (prev_stall && !cpu_stall) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", cpu_rdata, 32'h0);
                    end else begin
                        r = exp_q.pop_front();
                        if (r.chk_rdata) check("cpu_rdata", cpu_rdata, r.rdata);
                        check("bus_err", {31'b0, bus_err}, {31'b0, r.err});
                        check("err_addr", err_addr, r.eaddr);
                        check("stall_cycles", stall_cnt, r.stall);
                    end
                    stall_cnt = 0;
                end
                if (cpu_stall) stall_cnt++;
                prev_stall = cpu_stall;
            end
        end
    end

    // Slave-enable monitor: one pulse per mapped access, bus fields stable.
    initial begin
        logic       in_pulse;
        logic       have_exp;
        logic       fields_bad;
        int         pulse_len;
        logic [3:0] pulse_en;
        en_t        cur;
        in_pulse   = 1'b0;
        have_exp   = 1'b0;
        fields_bad = 1'b0;
        pulse_len  = 0;
        pulse_en   = '0;
        cur        = '{default: '0};
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_pulse = 1'b0;
            end else if (slv_en != '0) begin
                if (!in_pulse) begin
                    in_pulse   = 1'b1;
                    pulse_len  = 1;
                    pulse_en   = slv_en;
                    fields_bad = 1'b0;
                    if (en_q.size() == 0) begin
                        have_exp = 1'b0;
                        check("unexpected_slv_en", {28'b0, slv_en}, 32'h0);
                    end else begin
                        have_exp = 1'b1;
                        cur = en_q.pop_front();
                        check("slv_we", {31'b0, slv_we}, {31'b0, cur.we});
                        check("slv_addr", slv_addr, cur.addr);
                        check("slv_sel", {28'b0, slv_sel}, {28'b0, cur.sel});
                        check("slv_wdata", slv_wdata, cur.wdata);
                    end
                end else begin
                    pulse_len++;
                    if (slv_en != pulse_en || slv_we !== cur.we || slv_addr !== cur.addr ||
                        slv_sel !== cur.sel || slv_wdata !== cur.wdata) fields_bad = 1'b1;
                end
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                if (have_exp) begin
                    check("slv_en_value", {28'b0, pulse_en}, {28'b0, cur.en});
                    check("slv_en_cycles", pulse_len, cur.cycles);
                    check("slv_fields_stable", {31'b0, fields_bad}, 32'h0);
                end
            end
        end
    end

    task automatic push_resp(input logic [31:0] rdata, input logic chk, input logic err,
                             input logic [31:0] eaddr, input int stall);
        resp_t r;
        r.rdata = rdata; r.chk_rdata = chk; r.err = err; r.eaddr = eaddr; r.stall = stall;
        exp_q.push_back(r);
    endtask

    task automatic push_en(input logic [3:0] en, input int cycles, input logic we,
                           input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] wdata);
        en_t e;
        e.en = en; e.cycles = cycles; e.we = we; e.addr = addr; e.sel = sel; e.wdata = wdata;
        en_q.push_back(e);
    endtask

    // Drive one request and hold it until the DUT releases the stall.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] wdata, input int wait_c, input logic stray);
        logic done;
        ack_wait = wait_c;
        stray_en = stray;
        @(posedge clk);
        #1;
        cpu_en = 1'b1; cpu_we = we; cpu_addr = addr; cpu_sel = sel; cpu_wdata = wdata;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (!cpu_stall) done = 1'b1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL access_timeout: addr %h still stalled after 100 cycles", addr);
            rst = 1'b0;
            #1;
            exp_q.delete();
            en_q.delete();
            @(posedge clk);
            #1;
            rst = 1'b1;
        end
        @(posedge clk);
        #1;
        cpu_en = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
        stray_en = 1'b0;
    endtask

    initial begin
        // reset state, with cpu_en high to show the stall is held low
        cpu_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_stall", {31'b0, cpu_stall}, 32'h0);
        check("rst_slv_en", {28'b0, slv_en}, 32'h0);
        check("rst_slv_we", {31'b0, slv_we}, 32'h0);
        check("rst_slv_addr", slv_addr, 32'h0);
        check("rst_slv_sel", {28'b0, slv_sel}, 32'h0);
        check("rst_slv_wdata", slv_wdata, 32'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_bus_err", {31'b0, bus_err}, 32'h0);
        check("rst_err_addr", err_addr, 32'h0);
        cpu_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // zero-wait read from slave 0
        push_resp(32'h1234_5678, 1'b1, 1'b0, 32'h0, 2);
        push_en(4'b0001, 1, 1'b0, 32'h0000_0010, 4'b1111, 32'h0);
        issue(1'b0, 32'h0000_0010, 4'b1111, 32'h0, 0, 1'b0);

        // write to slave 1 with three wait cycles
        push_resp(32'h0, 1'b0, 1'b0, 32'h0, 5);
        push_en(4'b0010, 4, 1'b1, 32'h1000_0004, 4'b0011, 32'hAABB_CCDD);
        issue(1'b1, 32'h1000_0004, 4'b0011, 32'hAABB_CCDD, 3, 1'b0);

        // unmapped region 7
        push_resp(32'hDEAD_BEEF, 1'b1, 1'b1, 32'h7000_0000, 1);
        issue(1'b0, 32'h7000_0000, 4'b1111, 32'h0, 0, 1'b0);

        // stray acks on channel 2 while slave 0 waits two cycles
        push_resp(32'h1234_5678, 1'b1, 1'b1, 32'h7000_0000, 4);
        push_en(4'b0001, 3, 1'b0, 32'h0000_0020, 4'b1111, 32'h0);
        issue(1'b0, 32'h0000_0020, 4'b1111, 32'h0, 2, 1'b1);

        // highest mapped slave, one wait cycle
        push_resp(32'h3333_0003, 1'b1, 1'b1, 32'h7000_0000, 3);
        push_en(4'b1000, 2, 1'b0, 32'h3000_0008, 4'b1100, 32'h0);
        issue(1'b0, 32'h3000_0008, 4'b1100, 32'h0, 1, 1'b0);

`ifdef MMIO_TIMEOUT_EN
        // slave 3 never acks: abort after 16 enabled cycles
        push_resp(32'hDEAD_BEEF, 1'b1, 1'b1, 32'h3000_0000, 17);
        push_en(4'b1000, 16, 1'b0, 32'h3000_0000, 4'b1111, 32'h0);
        issue(1'b0, 32'h3000_0000, 4'b1111, 32'h0, 1000, 1'b0);
`endif

        // first unmapped region boundary
        push_resp(32'hDEAD_BEEF, 1'b1, 1'b1, 32'h4000_00FC, 1);
        issue(1'b0, 32'h4000_00FC, 4'b1111, 32'h0, 0, 1'b0);

        // reset during a waited access
        ack_wait = 10;
        push_en(4'b0001, 11, 1'b0, 32'h0000_0040, 4'b1111, 32'h0);
        @(posedge clk);
        #1;
        cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040; cpu_sel = 4'b1111;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midrst_slv_en", {28'b0, slv_en}, 32'h0);
        check("midrst_cpu_stall", {31'b0, cpu_stall}, 32'h0);
        check("midrst_bus_err", {31'b0, bus_err}, 32'h0);
        check("midrst_err_addr", err_addr, 32'h0);
        check("midrst_cpu_rdata", cpu_rdata, 32'h0);
        en_q.delete();
        cpu_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        ack_wait = 0;
        force_ack = 4'b0001;
        @(posedge clk);
        #1;
        force_ack = '0;
        @(negedge clk);
        check("late_ack_stall", {31'b0, cpu_stall}, 32'h0);
        check("late_ack_slv_en", {28'b0, slv_en}, 32'h0);
        check("late_ack_rdata", cpu_rdata, 32'h0);

        // normal access after reset, error flag cleared
        push_resp(32'h2222_0002, 1'b1, 1'b0, 32'h0, 2);
        push_en(4'b0100, 1, 1'b0, 32'h2000_0000, 4'b0001, 32'h0);
        issue(1'b0, 32'h2000_0000, 4'b0001, 32'h0, 0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("resp_queue_drained", exp_q.size(), 32'h0);
        check("en_queue_drained", en_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_bus_ctrl.md
Name: mmio_bus_ctrl

Overview:
- Parametrised data-bus controller between the mips core's data port and NUM_SLV memory-mapped slaves: data ram, VGA frame memory, button/IO registers, and future peripherals.
- Supersedes the fixed point-to-point ram wiring at the top level.
- Decodes the address region, forwards one transaction at a time, and stalls the core until the selected slave acknowledges.
- Returns the read data and flags unmapped or timed-out accesses.

Parameters:
- NUM_SLV, 4, number of slave channels (1..16); slave i owns the region where cpu_addr[31:28]==i.
- TIMEOUT_CYC, 16, cycles in ACCESS without an ack before the access is aborted (only with MMIO_TIMEOUT_EN).
- ERR_DATA, 32'hDEADBEEF, read data returned on an unmapped or timed-out access.

Ports:
- clk  in  1  system clock (clk0 domain).
- rst  in  1  asynchronous reset, active-low.
- cpu_en  in  1  core requests an access this cycle.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  32  byte address.
- cpu_sel  in  4  byte-lane select.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data; valid in DONE.
- cpu_stall  out  1  core must hold its request and pipeline.
- slv_en  out  NUM_SLV  one-hot slave enable.
- slv_we  out  1  registered write enable, broadcast to all slaves.
- slv_addr  out  32  registered address, broadcast.
- slv_sel  out  4  registered byte select, broadcast.
- slv_wdata  out  32  registered write data, broadcast.
- slv_rdata  in  32*NUM_SLV  flattened read data; slave i occupies bits [32i+31:32i].
- slv_ack  in  NUM_SLV  per-slave completion strobe.
- bus_err  out  1  sticky error flag.
- err_addr  out  32  address of the most recent failed access.

Behaviour:
Reset (rst=0, asynchronous): every output goes to 0 immediately.
- State becomes IDLE.
- Any in-flight access is dropped; no ack is awaited after reset.

FSM states: IDLE, ACCESS, DONE.

IDLE:
- cpu_stall = cpu_en (combinational).
- On cpu_en=1 with region < NUM_SLV: register we/addr/sel/wdata onto slv_*, set slv_en[region]=1, go to ACCESS.
- On cpu_en=1 with region >= NUM_SLV: no slave is enabled; rdata_q=ERR_DATA, bus_err=1, err_addr=cpu_addr, go to DONE.

ACCESS:
- cpu_stall=1 and slv_en stays held.
- A slave may ack in its first ACCESS cycle.
- On slv_ack[idx]=1: rdata_q = slv_rdata[idx]; the value is captured for writes too but is don't-care. Go to DONE, and slv_en drops on the same clock edge.
- Acks on non-selected channels are ignored.
- cpu_en dropping mid-ACCESS does not abort the access.

DONE:
- cpu_stall=0 and cpu_rdata=rdata_q; the core samples on this edge.
- Next state is always IDLE; no back-to-back issue from DONE.

Outside DONE, cpu_rdata holds its last value.

Latency:
- Request seen at cycle T, slave enabled at T+1, zero-wait ack at T+1, DONE at T+2, stall low at T+2.
- Minimum access is 3 cycles; each slave wait cycle adds 1.

bus_err is cleared only by reset.

Optional Feature:
MMIO_TIMEOUT_EN
- Defined: an 8-bit-or-wider counter clears on entry to ACCESS and increments each ACCESS cycle without an ack.
  - When it reaches TIMEOUT_CYC-1 without an ack: slv_en drops, rdata_q=ERR_DATA, bus_err=1, err_addr=slv_addr, go to DONE.
  - An ack arriving in that same cycle wins, and no error is raised.
- Undefined: there is no counter, and ACCESS waits indefinitely for an ack.

Test Plan:
- Zero-wait read: reset, then cpu_en=1, we=0, addr=0x0000_0010. Slave 0 acks on its first enable cycle with rdata 0x1234_5678 -> slv_en=4'b0001 for exactly 1 cycle, stall high for 2 cycles, cpu_rdata=0x1234_5678 at T+2, bus_err=0.
- Waited write: addr=0x1000_0004, sel=4'b0011, wdata=0xAABB_CCDD, slave 1 acks after 3 wait cycles -> slv_we=1, slv_sel=0011, slv_wdata=0xAABB_CCDD stable while slv_en[1]=1, stall deasserts at T+5.
- Unmapped: NUM_SLV=4, read addr=0x7000_0000 -> no slv_en bit set, stall high 1 cycle, cpu_rdata=0xDEADBEEF, bus_err=1, err_addr=0x7000_0000.
- Stray acks: slv_ack[2] pulses while slave 0 is selected -> ignored; completion waits for slv_ack[0].
- Timeout (MMIO_TIMEOUT_EN, TIMEOUT_CYC=16): slave 3 never acks -> slv_en[3] high for exactly 16 cycles, then DONE with 0xDEADBEEF, bus_err=1, err_addr=0x3000_0000.
- Reset mid-access: rst=0 during ACCESS with wait states pending -> slv_en=0, cpu_stall=0, bus_err=0 immediately; a later ack from the slave is ignored in IDLE.
